// File: rtl/lsu_pkg.sv
//------------------------------------------------------------------------------
// Module   : lsu_pkg
// Brief    : Shared widths, FSM state type and store-buffer entry for mem_lsu.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  localparam int DW       = 19;
  localparam int AW       = 8;
  localparam int SB_DEPTH = 4;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } lsu_state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } sb_entry_t;

endpackage

`default_nettype wire

// File: rtl/store_buffer.sv
//------------------------------------------------------------------------------
// Module   : store_buffer
// Brief    : In-order circular store FIFO with a youngest-match forwarding port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module store_buffer
  import lsu_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  sb_entry_t        push_entry,
  input  logic             pop,
  output sb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  input  logic [AW-1:0]    srch_addr,
  output logic             srch_hit,
  output logic [DW-1:0]    srch_data
);

  sb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through the valid count.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_tail] <= push_entry;
    end
  end

  // Scan oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    srch_hit  = 1'b0;
    srch_data = '0;
    w_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_mem[w_idx].addr == srch_addr)) begin
        srch_hit  = 1'b1;
        srch_data = r_mem[w_idx].data;
      end
    end
  end

  assign head  = r_mem[r_head];
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
//------------------------------------------------------------------------------
// Module   : mem_lsu
// Brief    : MEM-stage load/store initiator with posted stores and forwarding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_lsu
  import lsu_pkg::*;
#(
  parameter int DW       = lsu_pkg::DW,
  parameter int AW       = lsu_pkg::AW,
  parameter int SB_DEPTH = lsu_pkg::SB_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          req_ready,
  output logic          ld_valid,
  output logic [DW-1:0] ld_data,
  output logic          sb_empty,
  output logic          MEM_memread,
  output logic          MEM_memwrite,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int c_CNT_W = $clog2(SB_DEPTH) + 1;

  lsu_state_e         r_state;
  lsu_state_e         w_state_nxt;
  logic               r_ld_valid;
  logic [DW-1:0]      r_ld_data;

  logic               w_accept;
  logic               w_store;
  logic               w_load;
  logic               w_hit;
  logic               w_miss;
  logic               w_drain;
  sb_entry_t          w_push_entry;
  sb_entry_t          w_head;
  logic               w_sb_full;
  logic               w_sb_empty;
  logic [c_CNT_W-1:0] w_sb_count;
  logic               w_srch_hit;
  logic [DW-1:0]      w_srch_data;

  assign w_push_entry = '{addr: req_addr, data: req_wdata};

  store_buffer #(
    .DEPTH (SB_DEPTH)
  ) u_store_buffer (
    .clk        (clk),
    .reset      (reset),
    .push       (w_store),
    .push_entry (w_push_entry),
    .pop        (w_drain),
    .head       (w_head),
    .full       (w_sb_full),
    .empty      (w_sb_empty),
    .count      (w_sb_count),
    .srch_addr  (req_addr),
    .srch_hit   (w_srch_hit),
    .srch_data  (w_srch_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Port strobes are masked during reset so no stale buffered store escapes.
  always_comb begin
    w_state_nxt  = r_state;
    req_ready    = (r_state == IDLE) && !(req_we && w_sb_full);
    w_accept     = req_valid && req_ready && !reset;
    w_store      = w_accept && req_we;
    w_load       = w_accept && !req_we;
    w_hit        = w_load && w_srch_hit;
    w_miss       = w_load && !w_srch_hit;
    w_drain      = !w_sb_empty && !w_miss && !reset;
    MEM_memread  = w_miss;
    MEM_memwrite = w_drain;
    mem_addr     = '0;
    mem_wdata    = '0;

    if (w_miss) begin
      mem_addr = req_addr;
    end else if (w_drain) begin
      mem_addr  = w_head.addr;
      mem_wdata = w_head.data;
    end

    case (r_state)
      IDLE:    if (w_miss) w_state_nxt = RD_WAIT;
      RD_WAIT: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ld_valid <= 1'b0;
      r_ld_data  <= '0;
    end else begin
      r_ld_valid <= w_hit || (r_state == RD_WAIT);
      if (w_hit) begin
        r_ld_data <= w_srch_data;
      end else if (r_state == RD_WAIT) begin
        r_ld_data <= mem_rdata;
      end
    end
  end

  assign ld_valid = r_ld_valid;
  assign ld_data  = r_ld_data;
  assign sb_empty = w_sb_empty;

  a_strobe_excl : assert property (@(posedge clk) disable iff (reset)
    !(MEM_memread && MEM_memwrite));

  a_count_range : assert property (@(posedge clk) disable iff (reset)
    w_sb_count <= c_CNT_W'(SB_DEPTH));

endmodule

`default_nettype wire
